// File: rtl/core_pkg.sv
// Shared encodings for the execute stage: ALU ops, forwarding selects,
// M-extension funct3 codes, the M-engine state type and the pass-through control bundle.
package core_pkg;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_COPY_B = 4'd10;

   localparam logic [1:0] FWD_ID  = 2'd0;
   localparam logic [1:0] FWD_MA  = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;
   localparam logic [1:0] FWD_WB2 = 2'd3;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   typedef struct packed {
      logic [4:0] addr_d;
      logic       reg_wen;
      logic       mem_rw;
      logic [1:0] wb_sel;
      logic [2:0] funct3;
   } ctrl_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M engine: one shift-add or restoring-divide step per RUN cycle,
// sign correction applied combinationally while in DONE.
module muldiv_iter
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     count_q;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q;
   logic              neg_q;

   logic              is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     add_sum, trial, diff;
   logic [2*XLEN-1:0] acc_step, mul_fix;
   logic [XLEN-1:0]   div_half, div_fix;

   // Divide-by-zero needs no special path: restoring division yields an
   // all-ones quotient and the dividend as remainder, so the quotient sign is suppressed.
   always_comb begin
      is_div   = op[2];
      a_signed = !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
      b_signed = a_signed && (op != MD_MULHSU);
      a_neg    = a_signed && op_a[XLEN-1];
      b_neg    = b_signed && op_b[XLEN-1];
      mag_a    = a_neg ? -op_a : op_a;
      mag_b    = b_neg ? -op_b : op_b;
      if (!is_div)
         neg_d = a_neg ^ b_neg;
      else if (op[1])
         neg_d = a_neg;
      else
         neg_d = (a_neg ^ b_neg) && (op_b != '0);
   end

   always_comb begin
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff    = trial - {1'b0, opnd_q};
      if (!op_q[2])
         acc_step = {add_sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      // NOTE: state_d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      if (abort)
         state_d = MD_IDLE;
      else begin
         case (state_q)
            MD_IDLE: if (start) state_d = MD_RUN;
            MD_RUN:  if (count_q == CW'(XLEN - 1)) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the datapath registers are reset as well, so nothing leaves reset holding X.
         state_q <= MD_IDLE;
         count_q <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         neg_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the pre-edge values.
         state_q <= state_d;
         if (state_q == MD_IDLE && start && !abort) begin
            count_q <= '0;
            op_q    <= op;
            neg_q   <= neg_d;
            opnd_q  <= is_div ? mag_b : mag_a;
            acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
         end else if (state_q == MD_RUN && !abort) begin
            count_q <= count_q + CW'(1);
            acc_q   <= acc_step;
         end
      end
   end

   always_comb begin
      mul_fix  = neg_q ? -acc_q : acc_q;
      div_half = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      div_fix  = neg_q ? -div_half : div_half;
      if (op_q[2])
         result = div_fix;
      else if (op_q[1:0] == 2'b00)
         result = mul_fix[XLEN-1:0];
      else
         result = mul_fix[2*XLEN-1:XLEN];
   end

   assign busy = (state_q != MD_IDLE);
   assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage_m.sv
// Execute stage: operand forwarding, single-cycle ALU, optional iterative M-engine
// and the EX/MA pipeline register.
module ex_stage_m
   import core_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit M_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] data_a,
   input  logic [XLEN-1:0] data_b,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] fwd_ma,
   input  logic [XLEN-1:0] fwd_wb,
   input  logic [XLEN-1:0] fwd_wb2,
   input  logic [1:0]      fwd_sel_a,
   input  logic [1:0]      fwd_sel_b,
   input  logic            a_sel,
   input  logic            b_sel,
   input  logic [3:0]      alu_sel,
   input  logic            m_op,
   input  logic [2:0]      funct3,
   input  logic [4:0]      addr_d,
   input  logic            reg_wen,
   input  logic            mem_rw,
   input  logic [1:0]      wb_sel,
   output logic            stall,
   output logic            busy,
   output logic            out_valid,
   output logic            reg_wen_o,
   output logic            mem_rw_o,
   output logic [1:0]      wb_sel_o,
   output logic [2:0]      funct3_o,
   output logic [4:0]      addr_d_o,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] data_b_o,
   output logic [XLEN-1:0] pc_plus4_o
);

   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_result;
   logic [SHW-1:0]  shamt;
   logic            md_start, md_busy, md_done;
   logic [XLEN-1:0] md_result;
   ctrl_t           ctrl_in, m_ctrl_q;
   logic [XLEN-1:0] m_pc4_q, m_b_q;

   always_comb begin
      case (fwd_sel_a)
         FWD_ID:  fwd_a = data_a;
         FWD_MA:  fwd_a = fwd_ma;
         FWD_WB:  fwd_a = fwd_wb;
         default: fwd_a = fwd_wb2;
      endcase
      case (fwd_sel_b)
         FWD_ID:  fwd_b = data_b;
         FWD_MA:  fwd_b = fwd_ma;
         FWD_WB:  fwd_b = fwd_wb;
         default: fwd_b = fwd_wb2;
      endcase
   end

   assign op_a  = a_sel ? pc : fwd_a;
   assign op_b  = b_sel ? imm : fwd_b;
   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_result = '0;
      case (alu_sel)
         ALU_ADD:    alu_result = op_a + op_b;
         ALU_SUB:    alu_result = op_a - op_b;
         ALU_SLL:    alu_result = op_a << shamt;
         ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_XOR:    alu_result = op_a ^ op_b;
         ALU_SRL:    alu_result = op_a >> shamt;
         ALU_SRA:    alu_result = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:     alu_result = op_a | op_b;
         ALU_AND:    alu_result = op_a & op_b;
         ALU_COPY_B: alu_result = op_b;
         default:    alu_result = '0;
      endcase
   end

   // Accept only from IDLE; the held M-op stays in EX through DONE without re-triggering.
   assign md_start = M_EN && in_valid && m_op && !flush && !md_busy;
   assign stall    = md_start || (md_busy && !md_done && !flush);
   assign busy     = md_busy;

   generate
      if (M_EN) begin : g_md
         muldiv_iter #(.XLEN(XLEN)) u_muldiv (
            .clk    (clk),
            .reset  (reset),
            .start  (md_start),
            .abort  (flush),
            .op     (funct3),
            .op_a   (fwd_a),
            .op_b   (fwd_b),
            .busy   (md_busy),
            .done   (md_done),
            .result (md_result)
         );
      end else begin : g_no_md
         assign md_busy   = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate

   assign ctrl_in = '{addr_d: addr_d, reg_wen: reg_wen, mem_rw: mem_rw,
                      wb_sel: wb_sel, funct3: funct3};

   always_ff @(posedge clk) begin
      if (reset) begin
         m_ctrl_q <= '0;
         m_pc4_q  <= '0;
         m_b_q    <= '0;
      end else if (md_start) begin
         m_ctrl_q <= ctrl_in;
         m_pc4_q  <= pc_plus4;
         m_b_q    <= fwd_b;
      end
   end

   // Priority: reset, flush, M-engine completion, stall bubble, then the ALU path.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         reg_wen_o    <= 1'b0;
         mem_rw_o     <= 1'b0;
         wb_sel_o     <= '0;
         funct3_o     <= '0;
         addr_d_o     <= '0;
         alu_result_o <= '0;
         data_b_o     <= '0;
         pc_plus4_o   <= '0;
      end else if (flush || (stall && !md_done)) begin
         out_valid <= 1'b0;
         reg_wen_o <= 1'b0;
         mem_rw_o  <= 1'b0;
      end else if (md_done) begin
         out_valid    <= 1'b1;
         reg_wen_o    <= m_ctrl_q.reg_wen;
         mem_rw_o     <= m_ctrl_q.mem_rw;
         wb_sel_o     <= m_ctrl_q.wb_sel;
         funct3_o     <= m_ctrl_q.funct3;
         addr_d_o     <= m_ctrl_q.addr_d;
         alu_result_o <= md_result;
         data_b_o     <= m_b_q;
         pc_plus4_o   <= m_pc4_q;
      end else begin
         out_valid    <= in_valid;
         reg_wen_o    <= reg_wen && in_valid;
         mem_rw_o     <= mem_rw && in_valid;
         wb_sel_o     <= wb_sel;
         funct3_o     <= funct3;
         addr_d_o     <= addr_d;
         alu_result_o <= alu_result;
         data_b_o     <= fwd_b;
         pc_plus4_o   <= pc_plus4;
      end
   end

endmodule

// File: tb/tb_ex_stage_m.sv
// Directed plus randomized bench for ex_stage_m, checked against an arithmetic reference model.
module tb_ex_stage_m;
   import core_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, a_sel, b_sel, m_op, reg_wen, mem_rw;
   logic [XLEN-1:0] pc, pc_plus4, data_a, data_b, imm, fwd_ma, fwd_wb, fwd_wb2;
   logic [1:0]      fwd_sel_a, fwd_sel_b, wb_sel;
   logic [3:0]      alu_sel;
   logic [2:0]      funct3;
   logic [4:0]      addr_d;
   logic            stall, busy, out_valid, reg_wen_o, mem_rw_o;
   logic [1:0]      wb_sel_o;
   logic [2:0]      funct3_o;
   logic [4:0]      addr_d_o;
   logic [XLEN-1:0] alu_result_o, data_b_o, pc_plus4_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_stage_m #(.XLEN(XLEN), .M_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .pc(pc), .pc_plus4(pc_plus4), .data_a(data_a), .data_b(data_b), .imm(imm),
      .fwd_ma(fwd_ma), .fwd_wb(fwd_wb), .fwd_wb2(fwd_wb2),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .a_sel(a_sel), .b_sel(b_sel),
      .alu_sel(alu_sel), .m_op(m_op), .funct3(funct3), .addr_d(addr_d),
      .reg_wen(reg_wen), .mem_rw(mem_rw), .wb_sel(wb_sel),
      .stall(stall), .busy(busy), .out_valid(out_valid), .reg_wen_o(reg_wen_o),
      .mem_rw_o(mem_rw_o), .wb_sel_o(wb_sel_o), .funct3_o(funct3_o), .addr_d_o(addr_d_o),
      .alu_result_o(alu_result_o), .data_b_o(data_b_o), .pc_plus4_o(pc_plus4_o)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_SLL:    return a << b[4:0];
         ALU_SLT:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:    return a ^ b;
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return $unsigned(int'(a) >>> b[4:0]);
         ALU_OR:     return a | b;
         ALU_AND:    return a & b;
         ALU_COPY_B: return b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         MD_MUL:    begin p = sa * sb; return p[31:0];  end
         MD_MULH:   begin p = sa * sb; return p[63:32]; end
         MD_MULHSU: begin p = sa * ub; return p[63:32]; end
         MD_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(int'(a) / int'(b));
         MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         MD_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic set_op(input logic m, input logic [2:0] f3, input logic [3:0] op,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [1:0] sa, input logic [1:0] sb_in,
                         input logic asel, input logic bsel);
      logic [1:0] sb;
      sb = sb_in;
      if (sb == sa && sa != FWD_ID) sb = FWD_ID;
      data_a = $urandom; data_b = $urandom; fwd_ma = $urandom; fwd_wb = $urandom; fwd_wb2 = $urandom;
      pc = $urandom; pc_plus4 = pc + 32'd4; imm = $urandom;
      addr_d = 5'($urandom_range(0, 31)); wb_sel = 2'($urandom_range(0, 3));
      reg_wen = 1'($urandom_range(0, 1)); mem_rw = 1'($urandom_range(0, 1));
      case (sa)
         FWD_ID:  data_a  = va;
         FWD_MA:  fwd_ma  = va;
         FWD_WB:  fwd_wb  = va;
         default: fwd_wb2 = va;
      endcase
      case (sb)
         FWD_ID:  data_b  = vb;
         FWD_MA:  fwd_ma  = vb;
         FWD_WB:  fwd_wb  = vb;
         default: fwd_wb2 = vb;
      endcase
      fwd_sel_a = sa; fwd_sel_b = sb; a_sel = asel; b_sel = bsel;
      alu_sel = op; m_op = m; funct3 = f3; in_valid = 1'b1;
   endtask

   task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic [1:0] sa, input logic [1:0] sb, input logic asel, input logic bsel);
      logic [31:0] exp_r, e_pc4;
      logic [4:0]  e_rd;
      logic        e_we;
      set_op(1'b0, 3'($urandom_range(0, 7)), op, va, vb, sa, sb, asel, bsel);
      exp_r = alu_ref(op, asel ? pc : va, bsel ? imm : vb);
      e_pc4 = pc_plus4; e_rd = addr_d; e_we = reg_wen;
      #1;
      check({tag, "/stall"}, stall, 0);
      tick();
      in_valid = 1'b0;
      check({tag, "/result"}, alu_result_o, exp_r);
      check({tag, "/valid"}, out_valid, 1);
      check({tag, "/data_b"}, data_b_o, vb);
      check({tag, "/pc4"}, pc_plus4_o, e_pc4);
      check({tag, "/rd"}, addr_d_o, 32'(e_rd));
      check({tag, "/we"}, reg_wen_o, 32'(e_we));
   endtask

   task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] va, input logic [31:0] vb,
                          input logic [1:0] sa, input logic [1:0] sb);
      logic [31:0] e_pc4;
      logic [4:0]  e_rd;
      logic        e_we, e_mrw;
      int          n;
      set_op(1'b1, f3, 4'($urandom_range(0, 10)), va, vb, sa, sb, 1'b0, 1'b0);
      e_pc4 = pc_plus4; e_rd = addr_d; e_we = reg_wen; e_mrw = mem_rw;
      #1;
      check({tag, "/stall_accept"}, stall, 1);
      n = 0;
      while (stall === 1'b1 && n < 200) begin
         tick();
         n++;
         fwd_ma = $urandom; fwd_wb = $urandom; fwd_wb2 = $urandom;
         if (n == 1) begin
            check({tag, "/bubble"}, out_valid, 0);
            check({tag, "/busy_run"}, busy, 1);
         end
      end
      check({tag, "/stall_cycles"}, 32'(n), 32'(XLEN + 1));
      check({tag, "/busy_done"}, busy, 1);
      in_valid = 1'b0;
      m_op     = 1'b0;
      tick();
      check({tag, "/result"}, alu_result_o, m_ref(f3, va, vb));
      check({tag, "/valid"}, out_valid, 1);
      check({tag, "/data_b"}, data_b_o, vb);
      check({tag, "/pc4"}, pc_plus4_o, e_pc4);
      check({tag, "/rd"}, addr_d_o, 32'(e_rd));
      check({tag, "/funct3"}, funct3_o, 32'(f3));
      check({tag, "/we"}, reg_wen_o, 32'(e_we));
      check({tag, "/mrw"}, mem_rw_o, 32'(e_mrw));
      check({tag, "/busy_after"}, busy, 0);
   endtask

   initial begin
      logic [31:0] specials [4];
      logic [31:0] ra, rb;
      specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'h8000_0000; specials[3] = 32'hFFFF_FFFF;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; m_op = 1'b0; a_sel = 1'b0; b_sel = 1'b0;
      pc = '0; pc_plus4 = '0; data_a = '0; data_b = '0; imm = '0;
      fwd_ma = '0; fwd_wb = '0; fwd_wb2 = '0; fwd_sel_a = '0; fwd_sel_b = '0;
      alu_sel = '0; funct3 = '0; addr_d = '0; reg_wen = 1'b0; mem_rw = 1'b0; wb_sel = '0;
      tick();
      tick();
      reset = 1'b0;
      check("reset/out_valid", out_valid, 0);
      check("reset/result", alu_result_o, 0);
      check("reset/data_b", data_b_o, 0);
      check("reset/pc4", pc_plus4_o, 0);
      check("reset/stall", stall, 0);
      check("reset/busy", busy, 0);

      run_alu("add_fwd", ALU_ADD, 32'd5, 32'd7, FWD_MA, FWD_ID, 1'b0, 1'b0);
      check("add_fwd/exact", alu_result_o, 32'd12);

      run_mop("mulh", MD_MULH, 32'hFFFF_FFFD, 32'h4000_0000, FWD_ID, FWD_ID);
      check("mulh/exact", alu_result_o, 32'hFFFF_FFFF);
      run_mop("div0", MD_DIV, 32'd100, 32'd0, FWD_MA, FWD_ID);
      check("div0/exact", alu_result_o, 32'hFFFF_FFFF);
      run_mop("rem0", MD_REM, 32'd100, 32'd0, FWD_ID, FWD_WB);
      check("rem0/exact", alu_result_o, 32'd100);
      run_mop("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, FWD_WB2, FWD_ID);
      check("div_ovf/exact", alu_result_o, 32'h8000_0000);
      run_mop("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, FWD_ID, FWD_ID);
      check("rem_ovf/exact", alu_result_o, 32'd0);

      set_op(1'b1, MD_DIV, ALU_ADD, 32'd1234, 32'd7, FWD_ID, FWD_ID, 1'b0, 1'b0);
      repeat (10) tick();
      flush = 1'b1;
      #1;
      check("flush/stall", stall, 0);
      tick();
      flush = 1'b0;
      check("flush/out_valid", out_valid, 0);
      check("flush/busy", busy, 0);
      run_alu("after_flush", ALU_ADD, 32'd40, 32'd2, FWD_ID, FWD_ID, 1'b0, 1'b0);

      set_op(1'b1, MD_MUL, ALU_ADD, 32'd99, 32'd3, FWD_ID, FWD_ID, 1'b0, 1'b0);
      repeat (5) tick();
      reset = 1'b1;
      in_valid = 1'b0;
      m_op = 1'b0;
      tick();
      reset = 1'b0;
      check("rst_run/result", alu_result_o, 0);
      check("rst_run/out_valid", out_valid, 0);
      check("rst_run/data_b", data_b_o, 0);
      check("rst_run/pc4", pc_plus4_o, 0);
      check("rst_run/rd", addr_d_o, 0);
      check("rst_run/busy", busy, 0);
      check("rst_run/stall", stall, 0);
      run_mop("divu", MD_DIVU, 32'd7, 32'd2, FWD_ID, FWD_ID);
      check("divu/exact", alu_result_o, 32'd3);

      for (int i = 0; i < 24; i++) begin
         run_alu("rand_alu", 4'($urandom_range(0, 10)), $urandom, $urandom,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 12; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
         run_mop("rand_m", 3'($urandom_range(0, 7)), ra, rb,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
